pwm_timebase: RTL and testbench

Timebase counter that sits directly upstream of the PWM waveform generator. It drives the generator's count_val, period, compare1 and compare2 inputs. It prescales the peripheral clock and runs an up or down counter that wraps at a programmable period. Period, compare values and direction pass through shadow registers, reloaded only at wrap, so the generator never sees a mid-period configuration change.

---
 rtl/pwm_timebase_if.sv | 32 +++
 rtl/pwm_timebase.sv | 114 +++++++++++
 tb/tb_pwm_timebase.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_timebase_if.sv
// Bus between the PWM timebase and its neighbours.
// master: configuration source / PWM generator side (drives en, cnt_clr, dir_up_in,
//         prescale, period_in, compare1_in, compare2_in; observes the timebase outputs).
// slave:  the timebase itself (drives count_val, period, compare1, compare2, dir_up, ovf).
interface pwm_timebase_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 8
);
  logic             en;
  logic             cnt_clr;
  logic             dir_up_in;
  logic [PSC_W-1:0] prescale;
  logic [CNT_W-1:0] period_in;
  logic [CNT_W-1:0] compare1_in;
  logic [CNT_W-1:0] compare2_in;
  logic [CNT_W-1:0] count_val;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] compare1;
  logic [CNT_W-1:0] compare2;
  logic             dir_up;
  logic             ovf;

  modport master (
    output en, cnt_clr, dir_up_in, prescale, period_in, compare1_in, compare2_in,
    input  count_val, period, compare1, compare2, dir_up, ovf
  );

  modport slave (
    input  en, cnt_clr, dir_up_in, prescale, period_in, compare1_in, compare2_in,
    output count_val, period, compare1, compare2, dir_up, ovf
  );
endinterface

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaled up/down counter wrapping at a programmable period.
// Period, compare values and direction are shadowed and reload only at wrap (or
// continuously while disabled / on clear), so the downstream generator never sees a
// mid-period configuration change.
// Ports:
//   clk   - peripheral clock
//   rst_n - asynchronous active-low reset
//   bus   - pwm_timebase_if slave modport (control/config in, count/shadows/ovf out)
module pwm_timebase #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  pwm_timebase_if.slave   bus
);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cmp1_q, cmp1_d;
  logic [CNT_W-1:0] cmp2_q, cmp2_d;
  logic             dir_q, dir_d;
  logic             ovf_q, ovf_d;

  logic tick;
  logic up_wrap;
  logic dn_wrap;
  logic load;

  assign tick = bus.en && (psc_q == bus.prescale);
  // >= and > recover cleanly when the period shrinks below the current count.
  assign up_wrap = (count_q >= period_q);
  assign dn_wrap = (count_q == '0) || (count_q > period_q);

  always_comb begin
    psc_d    = psc_q;
    count_d  = count_q;
    period_d = period_q;
    cmp1_d   = cmp1_q;
    cmp2_d   = cmp2_q;
    dir_d    = dir_q;
    ovf_d    = 1'b0;
    load     = 1'b0;

    if (bus.cnt_clr) begin
      psc_d   = '0;
      load    = 1'b1;
      count_d = bus.dir_up_in ? '0 : bus.period_in;
    end else if (!bus.en) begin
      // Disabled: count holds, shadows are transparent.
      psc_d = '0;
      load  = 1'b1;
    end else if (tick) begin
      psc_d = '0;
      if (dir_q) begin
        if (up_wrap) begin
          count_d = '0;
          ovf_d   = 1'b1;
          load    = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else begin
        if (dn_wrap) begin
          // Reload from the incoming period so a new period takes effect at once.
          count_d = bus.period_in;
          ovf_d   = 1'b1;
          load    = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
    end else begin
      // May run past a freshly lowered prescale; it wraps through max and recovers.
      psc_d = psc_q + PSC_W'(1);
    end

    if (load) begin
      period_d = bus.period_in;
      cmp1_d   = bus.compare1_in;
      cmp2_d   = bus.compare2_in;
      dir_d    = bus.dir_up_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q    <= '0;
      count_q  <= '0;
      period_q <= '0;
      cmp1_q   <= '0;
      cmp2_q   <= '0;
      dir_q    <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      psc_q    <= psc_d;
      count_q  <= count_d;
      period_q <= period_d;
      cmp1_q   <= cmp1_d;
      cmp2_q   <= cmp2_d;
      dir_q    <= dir_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.count_val = count_q;
  assign bus.period    = period_q;
  assign bus.compare1  = cmp1_q;
  assign bus.compare2  = cmp2_q;
  assign bus.dir_up    = dir_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pwm_timebase.sv
module tb_pwm_timebase;

  logic clk;
  logic rst_n;

  pwm_timebase_if #(.CNT_W(16), .PSC_W(8)) bus ();

  pwm_timebase #(.CNT_W(16), .PSC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic        dir;
    logic [7:0]  psc;
    logic [15:0] per;
    logic [15:0] c1;
    logic [15:0] c2;
    logic [15:0] e_cnt;
    logic [15:0] e_per;
    logic [15:0] e_c1;
    logic [15:0] e_c2;
    logic        e_dir;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];
  int n_tests;
  int n_fail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic clr, input logic dir, input logic [7:0] psc,
                     input logic [15:0] per, input logic [15:0] c1, input logic [15:0] c2,
                     input logic [15:0] e_cnt, input logic [15:0] e_per,
                     input logic [15:0] e_c1, input logic [15:0] e_c2,
                     input logic e_dir, input logic e_ovf);
    vec_t v;
    v = '{en, clr, dir, psc, per, c1, c2, e_cnt, e_per, e_c1, e_c2, e_dir, e_ovf};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic en, input logic clr, input logic dir, input logic [7:0] psc,
                       input logic [15:0] per);
    bus.en        = en;
    bus.cnt_clr   = clr;
    bus.dir_up_in = dir;
    bus.prescale  = psc;
    bus.period_in = per;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Up, prescale 0, period 3 (one disabled cycle loads the shadows first).
    add(0, 0, 1, 0, 3, 7, 9,   0, 3, 7, 9, 1, 0);
    add(1, 0, 1, 0, 3, 7, 9,   1, 3, 7, 9, 1, 0);
    add(1, 0, 1, 0, 3, 7, 9,   2, 3, 7, 9, 1, 0);
    add(1, 0, 1, 0, 3, 7, 9,   3, 3, 7, 9, 1, 0);
    add(1, 0, 1, 0, 3, 7, 9,   0, 3, 7, 9, 1, 1);
    add(1, 0, 1, 0, 3, 7, 9,   1, 3, 7, 9, 1, 0);
    // Down, period 4, started by cnt_clr.
    add(1, 1, 0, 0, 4, 7, 9,   4, 4, 7, 9, 0, 0);
    add(1, 0, 0, 0, 4, 7, 9,   3, 4, 7, 9, 0, 0);
    add(1, 0, 0, 0, 4, 7, 9,   2, 4, 7, 9, 0, 0);
    add(1, 0, 0, 0, 4, 7, 9,   1, 4, 7, 9, 0, 0);
    add(1, 0, 0, 0, 4, 7, 9,   0, 4, 7, 9, 0, 0);
    add(1, 0, 0, 0, 4, 7, 9,   4, 4, 7, 9, 0, 1);
    // Shadowing: period 5, reprogram at count 1; change lands only at wrap.
    add(1, 1, 1, 0, 5, 0, 0,   0, 5, 0, 0, 1, 0);
    add(1, 0, 1, 0, 5, 0, 0,   1, 5, 0, 0, 1, 0);
    add(1, 0, 1, 0, 2, 1, 3,   2, 5, 0, 0, 1, 0);
    add(1, 0, 1, 0, 2, 1, 3,   3, 5, 0, 0, 1, 0);
    add(1, 0, 1, 0, 2, 1, 3,   4, 5, 0, 0, 1, 0);
    add(1, 0, 1, 0, 2, 1, 3,   5, 5, 0, 0, 1, 0);
    add(1, 0, 1, 0, 2, 1, 3,   0, 2, 1, 3, 1, 1);
    add(1, 0, 1, 0, 2, 1, 3,   1, 2, 1, 3, 1, 0);
    add(1, 0, 1, 0, 2, 1, 3,   2, 2, 1, 3, 1, 0);
    add(1, 0, 1, 0, 2, 1, 3,   0, 2, 1, 3, 1, 1);
    // Shrink while disabled: count 7, period becomes 3 -> first tick wraps.
    add(1, 1, 1, 0, 9, 0, 0,   0, 9, 0, 0, 1, 0);
    for (int k = 1; k <= 7; k++) add(1, 0, 1, 0, 9, 0, 0, 16'(k), 9, 0, 0, 1, 0);
    add(0, 0, 1, 0, 3, 0, 0,   7, 3, 0, 0, 1, 0);
    add(1, 0, 1, 0, 3, 0, 0,   0, 3, 0, 0, 1, 1);
    // Period 0: every tick wraps; cnt_clr on a tick suppresses ovf.
    add(1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1);
    add(1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
    // Down shrink while disabled: count 5 > new period 3 -> reload to 3.
    add(1, 1, 0, 0, 6, 0, 0,   6, 6, 0, 0, 0, 0);
    add(1, 0, 0, 0, 6, 0, 0,   5, 6, 0, 0, 0, 0);
    add(0, 0, 0, 0, 3, 0, 0,   5, 3, 0, 0, 0, 0);
    add(1, 0, 0, 0, 3, 0, 0,   3, 3, 0, 0, 0, 1);
    add(1, 0, 0, 0, 3, 0, 0,   2, 3, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 1, 0, 0);
    bus.compare1_in = '0;
    bus.compare2_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst cnt", bus.count_val, 0);
    check("rst per", bus.period, 0);
    check("rst c1",  bus.compare1, 0);
    check("rst c2",  bus.compare2, 0);
    check("rst dir", bus.dir_up, 1);
    check("rst ovf", bus.ovf, 0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].dir, vecs[i].psc, vecs[i].per);
      bus.compare1_in = vecs[i].c1;
      bus.compare2_in = vecs[i].c2;
      step();
      check($sformatf("vec%0d cnt", i), bus.count_val, vecs[i].e_cnt);
      check($sformatf("vec%0d per", i), bus.period,    vecs[i].e_per);
      check($sformatf("vec%0d c1",  i), bus.compare1,  vecs[i].e_c1);
      check($sformatf("vec%0d c2",  i), bus.compare2,  vecs[i].e_c2);
      check($sformatf("vec%0d dir", i), bus.dir_up,    vecs[i].e_dir);
      check($sformatf("vec%0d ovf", i), bus.ovf,       vecs[i].e_ovf);
    end

    // Up, prescale 2, period 2: each value held 3 clocks, ovf every 9 clocks.
    bus.compare1_in = '0;
    bus.compare2_in = '0;
    drive(1, 1, 1, 2, 2);
    step();
    check("psc2 clr cnt", bus.count_val, 0);
    bus.cnt_clr = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      check($sformatf("psc2 k%0d cnt", k), bus.count_val, 16'(((k / 3) % 3)));
      check($sformatf("psc2 k%0d ovf", k), bus.ovf, (k % 9) == 0);
    end

    // Lowering prescale below psc_cnt must not lock up the counter.
    drive(1, 1, 1, 5, 10);
    step();
    bus.cnt_clr = 1'b0;
    repeat (4) step();
    bus.prescale = 8'd1;
    begin
      int waited;
      waited = 0;
      while (bus.count_val == 16'd0 && waited < 400) begin
        step();
        waited++;
      end
      check("psc lower advances", bus.count_val, 1);
    end

    // Async reset mid-run at count 9 with prescale 5.
    drive(1, 1, 1, 5, 20);
    step();
    bus.cnt_clr = 1'b0;
    repeat (54) step();
    check("pre-rst cnt", bus.count_val, 9);
    check("pre-rst per", bus.period, 20);
    #1 rst_n = 1'b0;
    #1;
    check("async cnt", bus.count_val, 0);
    check("async per", bus.period, 0);
    check("async dir", bus.dir_up, 1);
    check("async ovf", bus.ovf, 0);
    bus.prescale = 8'd0;
    #2 rst_n = 1'b1;
    step();
    // Shadow period is 0 after reset, so the first tick is a wrap that loads 20.
    check("post-rst cnt0", bus.count_val, 0);
    check("post-rst ovf",  bus.ovf, 1);
    check("post-rst per",  bus.period, 20);
    step();
    check("post-rst cnt1", bus.count_val, 1);
    step();
    check("post-rst cnt2", bus.count_val, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
